// File: rtl/sevenseg_pkg.sv
// sevenseg_pkg
// Shared definitions for the multiplexed seven-segment driver.
//   seg_t         : 7-bit segment vector, {a,b,c,d,e,f,g} on bits 6..0
//   SEG_A..SEG_G  : bit position of each segment inside seg_t
//   SEG_0..SEG_HF : active-high glyphs for nibbles 0-9 and letters A,b,C,d,E,F
//   SEG_BLANK     : all segments off (active-high)
package sevenseg_pkg;

  typedef logic [6:0] seg_t;

  localparam int SEG_A = 6;  // top
  localparam int SEG_B = 5;  // upper-right
  localparam int SEG_C = 4;  // lower-right
  localparam int SEG_D = 3;  // bottom
  localparam int SEG_E = 2;  // lower-left
  localparam int SEG_F = 1;  // upper-left
  localparam int SEG_G = 0;  // middle

  // One-hot masks so every glyph below reads as the list of segments it lights.
  localparam seg_t SB_A = seg_t'(1 << SEG_A);
  localparam seg_t SB_B = seg_t'(1 << SEG_B);
  localparam seg_t SB_C = seg_t'(1 << SEG_C);
  localparam seg_t SB_D = seg_t'(1 << SEG_D);
  localparam seg_t SB_E = seg_t'(1 << SEG_E);
  localparam seg_t SB_F = seg_t'(1 << SEG_F);
  localparam seg_t SB_G = seg_t'(1 << SEG_G);

  localparam seg_t SEG_BLANK = 7'h00;
  localparam seg_t SEG_0  = SB_A | SB_B | SB_C | SB_D | SB_E | SB_F;
  localparam seg_t SEG_1  = SB_B | SB_C;
  localparam seg_t SEG_2  = SB_A | SB_B | SB_D | SB_E | SB_G;
  localparam seg_t SEG_3  = SB_A | SB_B | SB_C | SB_D | SB_G;
  localparam seg_t SEG_4  = SB_B | SB_C | SB_F | SB_G;
  localparam seg_t SEG_5  = SB_A | SB_C | SB_D | SB_F | SB_G;
  localparam seg_t SEG_6  = SB_A | SB_C | SB_D | SB_E | SB_F | SB_G;
  localparam seg_t SEG_7  = SB_A | SB_B | SB_C;
  localparam seg_t SEG_8  = SB_A | SB_B | SB_C | SB_D | SB_E | SB_F | SB_G;
  localparam seg_t SEG_9  = SB_A | SB_B | SB_C | SB_D | SB_F | SB_G;
  localparam seg_t SEG_HA = SB_A | SB_B | SB_C | SB_E | SB_F | SB_G;
  localparam seg_t SEG_HB = SB_C | SB_D | SB_E | SB_F | SB_G;
  localparam seg_t SEG_HC = SB_A | SB_D | SB_E | SB_F;
  localparam seg_t SEG_HD = SB_B | SB_C | SB_D | SB_E | SB_G;
  localparam seg_t SEG_HE = SB_A | SB_D | SB_E | SB_F | SB_G;
  localparam seg_t SEG_HF = SB_A | SB_E | SB_F | SB_G;

endpackage

// File: rtl/sevenseg_decode.sv
// sevenseg_decode
// Purely combinational nibble-to-glyph decoder (active-high segments).
//   nibble_i : 4-bit value to show
//   hex_en_i : 1 shows A-F as letters, 0 blanks any value above 9
//   seg_o    : segment vector {a,b,c,d,e,f,g}
module sevenseg_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       hex_en_i,
  output seg_t       seg_o
);

  // Glyph lookup; letters are gated by hex_en_i so a decimal-only
  // display never shows a half-readable letter.
  always_comb begin
    seg_o = SEG_BLANK;
    case (nibble_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = hex_en_i ? SEG_HA : SEG_BLANK;
      4'hB: seg_o = hex_en_i ? SEG_HB : SEG_BLANK;
      4'hC: seg_o = hex_en_i ? SEG_HC : SEG_BLANK;
      4'hD: seg_o = hex_en_i ? SEG_HD : SEG_BLANK;
      4'hE: seg_o = hex_en_i ? SEG_HE : SEG_BLANK;
      4'hF: seg_o = hex_en_i ? SEG_HF : SEG_BLANK;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sevenseg_scan.sv
// sevenseg_scan
// Time-multiplexed multi-digit seven-segment driver with a double-buffered
// load port, so new content only appears on a frame boundary.
//   clk        : system clock, rising edge
//   rst        : asynchronous active-high reset
//   load_valid : load_data holds a new display word
//   load_ready : pending buffer empty; load taken when valid && ready
//   load_data  : packed digits, nibble i = digit i, digit 0 least significant
//   seg        : registered segments {a..g}, polarity per ACTIVE_LOW
//   dig_en     : registered one-hot digit enable, polarity per ACTIVE_LOW
//   frame_done : one-cycle pulse the cycle after each frame boundary
// NUM_DIGITS must be >= 1 and DIV must be >= 2.
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIV        = 1000,
  parameter bit HEX_EN     = 1'b1,
  parameter bit BLANK_LZ   = 1'b1,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic                    frame_done
);

  localparam int PW = $clog2(DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  // Idle output levels: blank glyph and no digit enabled, after polarity.
  localparam seg_t                  SEG_IDLE = ACTIVE_LOW ? 7'h7F : SEG_BLANK;
  localparam logic [NUM_DIGITS-1:0] DIG_IDLE = {NUM_DIGITS{ACTIVE_LOW}};

  logic [PW-1:0]           prescale_q, prescale_d;
  logic [IW-1:0]           digitIdx_q, digitIdx_d;
  logic [4*NUM_DIGITS-1:0] display_q, display_d;
  logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
  logic                    pendingFull_q, pendingFull_d;
  logic                    loadReady_q;
  seg_t                    seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   digEn_q, digEn_d;
  logic                    frameDone_q;

  logic       atDigitEnd;
  logic       atFrameEnd;
  logic       loadAccept;
  logic [3:0] curNibble;
  logic       zeroRun;
  logic       leadBlank;
  seg_t       decSeg;

  assign atDigitEnd = (prescale_q == PRESC_LAST);
  assign atFrameEnd = atDigitEnd && (digitIdx_q == IDX_LAST);
  assign loadAccept = load_valid && loadReady_q;

  // Scan timing: the prescaler sets how long each digit stays lit and
  // the digit index steps once per prescaler wrap.
  always_comb begin
    prescale_d = prescale_q + 1'b1;
    digitIdx_d = digitIdx_q;
    if (atDigitEnd) begin
      prescale_d = '0;
      digitIdx_d = (digitIdx_q == IDX_LAST) ? '0 : digitIdx_q + 1'b1;
    end
  end

  // Double buffer. A frame boundary with a full pending buffer and an
  // accepted load are mutually exclusive, because ready is only high while
  // pending is empty; a load taken in the boundary cycle waits a full frame.
  always_comb begin
    display_d     = display_q;
    pending_d     = pending_q;
    pendingFull_d = pendingFull_q;
    if (atFrameEnd && pendingFull_q) begin
      display_d     = pending_q;
      pendingFull_d = 1'b0;
    end else if (loadAccept) begin
      pending_d     = load_data;
      pendingFull_d = 1'b1;
    end
  end

  // Pick the nibble belonging to the digit currently being scanned.
  always_comb begin
    curNibble = display_q[3:0];
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (digitIdx_q == IW'(i)) curNibble = display_q[4*i +: 4];
    end
  end

  // Leading-zero blanking: walking down from the top digit, zeroRun stays
  // set while every nibble so far is zero. Digit 0 is never blanked so an
  // all-zero word still shows a single "0".
  always_comb begin
    zeroRun   = 1'b1;
    leadBlank = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zeroRun = zeroRun && (display_q[4*i +: 4] == 4'h0);
      if (BLANK_LZ && (digitIdx_q == IW'(i))) leadBlank = zeroRun;
    end
  end

  sevenseg_decode u_decode (
    .nibble_i (curNibble),
    .hex_en_i (HEX_EN),
    .seg_o    (decSeg)
  );

  // Output register inputs; polarity is applied here so the pins come
  // straight off flops with no logic after them.
  always_comb begin
    seg_d   = (leadBlank ? SEG_BLANK : decSeg) ^ {7{ACTIVE_LOW}};
    digEn_d = DIG_IDLE;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      digEn_d[i] = (digitIdx_q == IW'(i)) ^ ACTIVE_LOW;
    end
  end

  // All state; reset blanks the display immediately, even mid-scan.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescale_q    <= '0;
      digitIdx_q    <= '0;
      display_q     <= '0;
      pending_q     <= '0;
      pendingFull_q <= 1'b0;
      loadReady_q   <= 1'b1;
      seg_q         <= SEG_IDLE;
      digEn_q       <= DIG_IDLE;
      frameDone_q   <= 1'b0;
    end else begin
      prescale_q    <= prescale_d;
      digitIdx_q    <= digitIdx_d;
      display_q     <= display_d;
      pending_q     <= pending_d;
      pendingFull_q <= pendingFull_d;
      loadReady_q   <= !pendingFull_d;
      seg_q         <= seg_d;
      digEn_q       <= digEn_d;
      frameDone_q   <= atFrameEnd;
    end
  end

  assign load_ready = loadReady_q;
  assign seg        = seg_q;
  assign dig_en     = digEn_q;
  assign frame_done = frameDone_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// tb_sevenseg_scan
// Four sevenseg_scan instances (NUM_DIGITS=4, DIV=4) share clock, reset and
// load stimulus:
//   0: hex on, leading-zero blanking on, active-high
//   1: hex off
//   2: leading-zero blanking off
//   3: active-low outputs
// Accepted words are queued and move to the expected display word at each
// frame boundary; every cycle the outputs of all instances are compared.
module tb_sevenseg_scan;

  localparam int ND    = 4;
  localparam int DV    = 4;
  localparam int NINST = 4;
  localparam int FRAME = ND * DV;

  logic        clk = 1'b0;
  logic        rst;
  logic        loadValid;
  logic [15:0] loadData;

  logic [6:0]  segW   [NINST];
  logic [3:0]  digW   [NINST];
  logic        readyW [NINST];
  logic        doneW  [NINST];

  int checks   = 0;
  int failures = 0;

  logic [15:0] modelShown;
  logic [15:0] pendQ [$];
  int          edgeCnt;
  bit          expValid;
  logic [6:0]  expSeg [NINST];
  logic [3:0]  expDig [NINST];
  logic        expDone;
  logic        expReady;

  always #5 clk = ~clk;

  sevenseg_scan #(.NUM_DIGITS(ND), .DIV(DV), .HEX_EN(1'b1), .BLANK_LZ(1'b1), .ACTIVE_LOW(1'b0)) dutMain (
    .clk(clk), .rst(rst), .load_valid(loadValid), .load_ready(readyW[0]), .load_data(loadData),
    .seg(segW[0]), .dig_en(digW[0]), .frame_done(doneW[0]));

  sevenseg_scan #(.NUM_DIGITS(ND), .DIV(DV), .HEX_EN(1'b0), .BLANK_LZ(1'b1), .ACTIVE_LOW(1'b0)) dutNoHex (
    .clk(clk), .rst(rst), .load_valid(loadValid), .load_ready(readyW[1]), .load_data(loadData),
    .seg(segW[1]), .dig_en(digW[1]), .frame_done(doneW[1]));

  sevenseg_scan #(.NUM_DIGITS(ND), .DIV(DV), .HEX_EN(1'b1), .BLANK_LZ(1'b0), .ACTIVE_LOW(1'b0)) dutNoLz (
    .clk(clk), .rst(rst), .load_valid(loadValid), .load_ready(readyW[2]), .load_data(loadData),
    .seg(segW[2]), .dig_en(digW[2]), .frame_done(doneW[2]));

  sevenseg_scan #(.NUM_DIGITS(ND), .DIV(DV), .HEX_EN(1'b1), .BLANK_LZ(1'b1), .ACTIVE_LOW(1'b1)) dutLow (
    .clk(clk), .rst(rst), .load_valid(loadValid), .load_ready(readyW[3]), .load_data(loadData),
    .seg(segW[3]), .dig_en(digW[3]), .frame_done(doneW[3]));

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference glyph table, written out independently of the design package.
  function automatic logic [6:0] refCode(input logic [3:0] n, input bit hexEn);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h7E;  4'h1: s = 7'h30;  4'h2: s = 7'h6D;  4'h3: s = 7'h79;
      4'h4: s = 7'h33;  4'h5: s = 7'h5B;  4'h6: s = 7'h5F;  4'h7: s = 7'h70;
      4'h8: s = 7'h7F;  4'h9: s = 7'h7B;
      4'hA: s = hexEn ? 7'h77 : 7'h00;
      4'hB: s = hexEn ? 7'h1F : 7'h00;
      4'hC: s = hexEn ? 7'h4E : 7'h00;
      4'hD: s = hexEn ? 7'h3D : 7'h00;
      4'hE: s = hexEn ? 7'h4F : 7'h00;
      default: s = hexEn ? 7'h47 : 7'h00;
    endcase
    return s;
  endfunction

  // Expected pin value of seg for one digit of a word on a given instance.
  function automatic logic [6:0] refSeg(input logic [15:0] word, input int digit, input int inst);
    bit hexEn = (inst != 1);
    bit lz    = (inst != 2);
    bit low   = (inst == 3);
    logic [15:0] upper;
    logic [6:0]  s;
    upper = word >> (4 * digit);
    if (lz && digit > 0 && upper == 16'h0) s = 7'h00;
    else s = refCode(upper[3:0], hexEn);
    return low ? ~s : s;
  endfunction

  function automatic logic [3:0] refDig(input int digit, input int inst);
    logic [3:0] d;
    d = 4'b0001 << digit;
    return (inst == 3) ? ~d : d;
  endfunction

  // Offer a word on the load port and hold it until it is taken; returns on
  // the falling edge after the accepting rising edge with valid dropped.
  task automatic applyStimulus(input logic [15:0] word);
    int waited = 0;
    loadValid = 1'b1;
    loadData  = word;
    while (readyW[0] !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 100) begin
      checkOutput("loadTimeout", {31'd0, readyW[0]}, 32'd1);
      loadValid = 1'b0;
    end else begin
      @(negedge clk);
      loadValid = 1'b0;
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard: on each rising edge work out what the outputs must be after
  // it, then move queued words into the shown word at frame boundaries and
  // queue newly accepted words; outputs are compared on the falling edge.
  initial begin
    modelShown = '0;
    edgeCnt    = 0;
    expValid   = 1'b0;
    forever begin
      @(posedge clk);
      if (rst) begin
        pendQ.delete();
        modelShown = '0;
        edgeCnt    = 0;
        expValid   = 1'b0;
      end else begin
        int  digit;
        bit  readyBefore;
        digit       = (edgeCnt / DV) % ND;
        readyBefore = (pendQ.size() == 0);
        for (int k = 0; k < NINST; k++) begin
          expSeg[k] = refSeg(modelShown, digit, k);
          expDig[k] = refDig(digit, k);
        end
        expDone = ((edgeCnt % FRAME) == FRAME - 1);
        if (expDone && pendQ.size() > 0) modelShown = pendQ.pop_front();
        if (loadValid && readyBefore) pendQ.push_back(loadData);
        expReady = (pendQ.size() == 0);
        edgeCnt++;
        expValid = 1'b1;
      end
      @(negedge clk);
      if (expValid && !rst) begin
        for (int k = 0; k < NINST; k++) begin
          checkOutput($sformatf("seg[%0d]@%0d", k, edgeCnt - 1), {25'd0, segW[k]}, {25'd0, expSeg[k]});
          checkOutput($sformatf("digEn[%0d]@%0d", k, edgeCnt - 1), {28'd0, digW[k]}, {28'd0, expDig[k]});
          checkOutput($sformatf("frameDone[%0d]@%0d", k, edgeCnt - 1), {31'd0, doneW[k]}, {31'd0, expDone});
          checkOutput($sformatf("loadReady[%0d]@%0d", k, edgeCnt - 1), {31'd0, readyW[k]}, {31'd0, expReady});
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    loadValid = 1'b0;
    loadData  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    $display("[TB] reset released, idle frame");
    waitCycles(20);

    $display("[TB] decimal word with a zero gap");
    applyStimulus(16'h0905);
    waitCycles(40);

    $display("[TB] hex letters");
    applyStimulus(16'hABCD);
    waitCycles(40);

    $display("[TB] all zeros");
    applyStimulus(16'h0000);
    waitCycles(40);

    $display("[TB] back-to-back loads stall on full pending");
    applyStimulus(16'h1234);
    applyStimulus(16'h5678);
    waitCycles(50);

    $display("[TB] single digit for polarity check");
    applyStimulus(16'h0008);
    waitCycles(40);

    $display("[TB] asynchronous reset mid-scan with pending full");
    applyStimulus(16'h4321);
    waitCycles(2);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < NINST; k++) begin
      checkOutput($sformatf("rstSeg[%0d]", k), {25'd0, segW[k]}, (k == 3) ? 32'h7F : 32'h00);
      checkOutput($sformatf("rstDigEn[%0d]", k), {28'd0, digW[k]}, (k == 3) ? 32'hF : 32'h0);
      checkOutput($sformatf("rstReady[%0d]", k), {31'd0, readyW[k]}, 32'd1);
      checkOutput($sformatf("rstDone[%0d]", k), {31'd0, doneW[k]}, 32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    waitCycles(40);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan.md
Name: sevenseg_scan

Overview:
Parametrised, time-multiplexed multi-digit seven-segment driver; next generation of the single-digit `sevenseg` decoder.
- Accepts a packed word of 4-bit digits through a valid/ready load port.
- Double-buffers the word so that display content changes only on a frame boundary, which prevents tearing.
- Scans one digit at a time, with optional hex decode and leading-zero blanking.
- Sits between the LC3 display/IO register and the board's shared-segment display pins.

Parameters:
- NUM_DIGITS, 4: number of digits scanned; must be ≥ 1.
- DIV, 1000: clk cycles each digit is lit; must be ≥ 2.
- HEX_EN, 1: 1 decodes nibbles A-F as letters; 0 blanks any nibble > 9.
- BLANK_LZ, 1: 1 enables leading-zero blanking.
- ACTIVE_LOW, 0: 1 inverts both seg and dig_en at the output register.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- load_valid  in  1  load_data is valid.
- load_ready  out  1  pending buffer is empty; a load is accepted when load_valid && load_ready.
- load_data  in  4*NUM_DIGITS  nibble i (bits 4i+3:4i) is digit i; digit 0 is least significant.
- seg  out  7  segments {a,b,c,d,e,f,g} on bits 6..0 (a=top, b=upper-right, c=lower-right, d=bottom, e=lower-left, f=upper-left, g=middle).
- dig_en  out  NUM_DIGITS  one-hot digit enable.
- frame_done  out  1  single-cycle pulse per completed frame.

Behaviour:
- Reset (async assert, applies immediately, including mid-scan or mid-load):
  - prescaler = 0, index = 0, display register = 0, pending empty.
  - load_ready = 1, frame_done = 0.
  - seg = blank, dig_en = all off (both polarity-adjusted).
- Scan:
  - Prescaler counts 0..DIV-1. At DIV-1 it wraps to 0 and index advances, wrapping NUM_DIGITS-1 → 0.
  - seg and dig_en are registered: one cycle of latency from an index change to the outputs.
  - Each digit is therefore lit for exactly DIV cycles.
- Frame boundary: the cycle where prescaler == DIV-1 and index == NUM_DIGITS-1.
  - If pending is full: display register ← pending, and pending becomes empty.
  - frame_done pulses high for one cycle on the following cycle.
- Load handshake:
  - load_ready is registered as !pending_full.
  - On accept, pending ← load_data and load_ready = 0 from the next cycle.
  - While pending is full, load_valid is ignored and pending is never overwritten.
  - After a transfer, load_ready = 1 on the next cycle.
  - A load accepted in the boundary cycle itself (pending empty) goes to pending, not directly to display; it is shown after the next boundary.
- Decode (active-high codes, hex):
  - Digits: 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70 8=7F 9=7B.
  - Letters (HEX_EN=1): A=77 b=1F C=4E d=3D E=4F F=47.
  - Blank = 00.
- Leading-zero blanking (BLANK_LZ=1): digit i (i > 0) is blanked if its nibble and every higher nibble are 0. Digit 0 is never blanked.
- Polarity: when ACTIVE_LOW=1, seg and dig_en are bitwise inverted. Blank then becomes 7F and "off" becomes all-ones.

Decomposition:
- Package sevenseg_pkg:
  - Segment bit-index constants SEG_A..SEG_G.
  - typedef seg_t (7-bit).
  - Code constants for 0-F and SEG_BLANK.
- Sub-module sevenseg_decode: combinational nibble + hex_en → seg_t.
- sevenseg_scan holds the prescaler, index, pending/display registers, blanking logic and output registers.

Test Plan:
All scenarios use NUM_DIGITS=4 and DIV=4 unless stated.

1. Reset: assert rst mid-scan with pending full → same cycle seg=00, dig_en=0000, load_ready=1. After release, the first frame shows digit0=7E and digits 1-3 blank.
2. Load 16'h0905 → load_ready=0 the next cycle; old zeros persist until the boundary. Next frame: d0=5B, d1=7E, d2=7B, d3=blank, with dig_en 0001→0010→0100→1000, 4 cycles each. frame_done pulses once per 16 cycles.
3. Load 16'hABCD with HEX_EN=1 → d0..d3 = 3D,4E,1F,77. Repeat with HEX_EN=0 → all four digits 00.
4. Load 16'h0000 → only d0 lit (7E). With BLANK_LZ=0 → all four digits show 7E.
5. Hold load_valid high with 16'h1234 then 16'h5678 → 1234 accepted and 5678 stalled (load_ready=0) until the boundary. 1234 is displayed; 5678 is accepted the cycle after the boundary and displayed one frame later, never corrupting 1234.
6. ACTIVE_LOW=1, load 16'h0008 → d0 seg=00, blanked digits seg=7F, dig_en=1110 during the d0 slot; during reset seg=7F and dig_en=1111.
